// File: rtl/rv_trace_pkg.sv
// Shared state encoding and widths for the trace recorder.
// RV_TRACE_RECORDER_TIMESTAMP_EN widens each stored entry by TS_WIDTH bits (see RV_TRACE_EW).
`ifndef RV_TRACE_PKG_SV
`define RV_TRACE_PKG_SV

`ifdef RV_TRACE_RECORDER_TIMESTAMP_EN
`define RV_TRACE_EW(tw) ((tw) + rv_trace_pkg::TS_WIDTH)
`else
`define RV_TRACE_EW(tw) (tw)
`endif

package rv_trace_pkg;
  localparam int TS_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

`endif

// File: rtl/rv_trace_recorder_if.sv
// Readout valid/ready port of the trace recorder; the recorder drives it as master.
// EW follows RV_TRACE_EW, so it grows when RV_TRACE_RECORDER_TIMESTAMP_EN is defined.
interface rv_trace_recorder_if #(
  parameter int EW = `RV_TRACE_EW(36)
);
  import rv_trace_pkg::*;

  logic          rd_valid_o;
  logic          rd_ready_i;
  logic [EW-1:0] rd_data_o;
  logic          rd_last_o;

  modport master (output rd_valid_o, output rd_data_o, output rd_last_o, input rd_ready_i);
  modport slave  (input rd_valid_o, input rd_data_o, input rd_last_o, output rd_ready_i);
endinterface

// File: rtl/rv_trace_ram.sv
// Simple dual-port trace buffer: one write port, one registered read port (block-RAM style).
module rv_trace_ram #(
  parameter int AW = 10,
  parameter int DW = 36
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/rv_trace_recorder.sv
// Circular trace capture with post-trigger window and oldest-first valid/ready readout.
// Optional per-entry cycle delta stamp under RV_TRACE_RECORDER_TIMESTAMP_EN.
module rv_trace_recorder
  import rv_trace_pkg::*;
#(
  parameter int TRACE_WIDTH = 36,
  parameter int DEPTH_LOG2  = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   trace_valid_i,
  input  logic [TRACE_WIDTH-1:0] trace_data_i,
  input  logic                   trap_i,
  input  logic                   sw_trig_i,
  input  logic                   arm_i,
  input  logic [DEPTH_LOG2-1:0]  post_trig_i,
  rv_trace_recorder_if.master    rd,
  output logic [1:0]             state_o,
  output logic [DEPTH_LOG2:0]    fill_o,
  output logic                   wrapped_o
);
  localparam int EW = `RV_TRACE_EW(TRACE_WIDTH);
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rem_q, rem_d, raddr;
  logic [DEPTH_LOG2:0]   fill_q, fill_d, iss_q, iss_d;
  logic                  wrapped_q, wrapped_d, wr_en, pop, issue;
  logic                  rdv_q, rdv_d, lst_q, lst_d;
  logic                  out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic                  sk_vld_q, sk_vld_d, sk_last_q, sk_last_d;
  logic [EW-1:0]         out_data_q, out_data_d, sk_data_q, sk_data_d;
  logic [EW-1:0]         wdata, ram_rdata;
  logic [1:0]            occ;

  assign wr_en = trace_valid_i && !arm_i && (state_q == ST_ARMED || state_q == ST_POST);
  assign pop   = out_vld_q && rd.rd_ready_i;
  assign occ   = {1'b0, out_vld_q} + {1'b0, sk_vld_q} + {1'b0, rdv_q};
  // Only issue a RAM read when the 2-entry skid is guaranteed room for its result.
  assign issue = (state_q == ST_DONE) && !arm_i && (iss_q != fill_q) && ((occ < 2'd2) || pop);
  assign raddr = wr_ptr_q - fill_q[DEPTH_LOG2-1:0] + iss_q[DEPTH_LOG2-1:0];

`ifdef RV_TRACE_RECORDER_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d, ts_inc;
  // Stored delta includes the write cycle itself, so spacing N edges records N.
  assign ts_inc = (ts_q == {TS_WIDTH{1'b1}}) ? ts_q : ts_q + 1'b1;
  assign ts_d   = (arm_i || wr_en) ? '0 : ts_inc;
  assign wdata  = {ts_inc, trace_data_i};
`else
  assign wdata  = trace_data_i;
`endif

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    wrapped_d = wrapped_q;
    rem_d     = rem_q;
    if (arm_i) begin
      state_d   = ST_ARMED;
      wr_ptr_d  = '0;
      fill_d    = '0;
      wrapped_d = 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (fill_q == FULL) wrapped_d = 1'b1;
        else                fill_d    = fill_q + 1'b1;
      end
      case (state_q)
        ST_ARMED: if (trap_i || sw_trig_i) begin
          rem_d   = post_trig_i;
          state_d = (post_trig_i == '0) ? ST_DONE : ST_POST;
        end
        ST_POST: if (wr_en) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == 1) state_d = ST_DONE;
        end
        ST_DONE: if (fill_q == '0 || (pop && out_last_q)) state_d = ST_IDLE;
        default: ;
      endcase
    end
  end

  always_comb begin
    iss_d      = (arm_i || state_q != ST_DONE) ? '0 : iss_q + {{DEPTH_LOG2{1'b0}}, issue};
    rdv_d      = issue;
    lst_d      = issue && (iss_q == fill_q - 1'b1);
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    sk_vld_d   = sk_vld_q;
    sk_data_d  = sk_data_q;
    sk_last_d  = sk_last_q;
    if (arm_i) begin
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
      sk_vld_d   = 1'b0;
    end else if (!out_vld_q || pop) begin
      if (sk_vld_q) begin
        out_vld_d  = 1'b1;
        out_data_d = sk_data_q;
        out_last_d = sk_last_q;
        sk_vld_d   = rdv_q;
        sk_data_d  = ram_rdata;
        sk_last_d  = lst_q;
      end else begin
        out_vld_d  = rdv_q;
        out_data_d = ram_rdata;
        out_last_d = lst_q;
      end
    end else if (rdv_q) begin
      sk_vld_d  = 1'b1;
      sk_data_d = ram_rdata;
      sk_last_d = lst_q;
    end
  end

  // Control and output state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      fill_q     <= '0;
      wrapped_q  <= 1'b0;
      rem_q      <= '0;
      iss_q      <= '0;
      rdv_q      <= 1'b0;
      lst_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      sk_vld_q   <= 1'b0;
      sk_last_q  <= 1'b0;
`ifdef RV_TRACE_RECORDER_TIMESTAMP_EN
      ts_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      fill_q     <= fill_d;
      wrapped_q  <= wrapped_d;
      rem_q      <= rem_d;
      iss_q      <= iss_d;
      rdv_q      <= rdv_d;
      lst_q      <= lst_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      sk_vld_q   <= sk_vld_d;
      sk_last_q  <= sk_last_d;
`ifdef RV_TRACE_RECORDER_TIMESTAMP_EN
      ts_q       <= ts_d;
`endif
    end
  end

  always_ff @(posedge clk_i) sk_data_q <= sk_data_d;

  rv_trace_ram #(.AW(DEPTH_LOG2), .DW(EW)) u_ram (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .re_i    (issue),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  assign rd.rd_valid_o = out_vld_q;
  assign rd.rd_data_o  = out_data_q;
  assign rd.rd_last_o  = out_last_q;
  assign state_o       = state_q;
  assign fill_o        = fill_q;
  assign wrapped_o     = wrapped_q;
endmodule

// File: tb/tb_rv_trace_recorder.sv
// Directed bench for rv_trace_recorder (DEPTH_LOG2=4, TRACE_WIDTH=36); timestamp case under RV_TRACE_RECORDER_TIMESTAMP_EN.
module tb_rv_trace_recorder;
  localparam int TW = 36;
  localparam int DL = 4;
  localparam int EW = `RV_TRACE_EW(TW);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trace_valid = 1'b0;
  logic [TW-1:0] trace_data = '0;
  logic          trap = 1'b0;
  logic          sw_trig = 1'b0;
  logic          arm = 1'b0;
  logic [DL-1:0] post_trig = '0;
  logic [1:0]    state;
  logic [DL:0]   fill;
  logic          wrapped;
  logic [EW-1:0] rx [0:31];
  int            n_cmp = 0;
  int            n_bad = 0;

  rv_trace_recorder_if #(.EW(EW)) rd_if ();

  rv_trace_recorder #(.TRACE_WIDTH(TW), .DEPTH_LOG2(DL)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .trace_valid_i (trace_valid),
    .trace_data_i  (trace_data),
    .trap_i        (trap),
    .sw_trig_i     (sw_trig),
    .arm_i         (arm),
    .post_trig_i   (post_trig),
    .rd            (rd_if),
    .state_o       (state),
    .fill_o        (fill),
    .wrapped_o     (wrapped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic put(input logic [TW-1:0] d);
    trace_valid = 1'b1;
    trace_data  = d;
    tick();
    trace_valid = 1'b0;
  endtask

  task automatic trig_now(input logic [DL-1:0] post);
    sw_trig   = 1'b1;
    post_trig = post;
    tick();
    sw_trig   = 1'b0;
  endtask

  task automatic drain(input int n_take, input int n_total, input logic [TW-1:0] first,
                       input bit bp, input bit consec);
    int       got = 0;
    bit       stalled = 1'b0;
    logic [EW:0] held = '0;
    for (int cyc = 0; cyc < 400 && got < n_take; cyc++) begin
      rd_if.rd_ready_i = bp ? ($urandom_range(0, 1) != 0) : 1'b1;
      if (consec && got > 0) chk("rd_cont", rd_if.rd_valid_o, 1);
      if (rd_if.rd_valid_o) begin
        if (stalled) chk("rd_stable", {rd_if.rd_last_o, rd_if.rd_data_o}, held);
        if (rd_if.rd_ready_i) begin
          rx[got] = rd_if.rd_data_o;
          chk("rd_data", rd_if.rd_data_o[TW-1:0], first + TW'(got));
          chk("rd_last", rd_if.rd_last_o, (got == n_total - 1));
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = {rd_if.rd_last_o, rd_if.rd_data_o};
        end
      end
      tick();
    end
    chk("rd_count", got, n_take);
  endtask

  initial begin
    rd_if.rd_ready_i = 1'b0;
    #2;
    chk("rst_state", state, 0);
    chk("rst_fill", fill, 0);
    chk("rst_wrapped", wrapped, 0);
    chk("rst_valid", rd_if.rd_valid_o, 0);
    chk("rst_last", rd_if.rd_last_o, 0);
    chk("rst_data", rd_if.rd_data_o, 0);
    tick();
    rst = 1'b0;
    tick();

    // Idle ignores trace and triggers.
    trace_valid = 1'b1; sw_trig = 1'b1; trap = 1'b1;
    tick();
    trace_valid = 1'b0; sw_trig = 1'b0; trap = 1'b0;
    chk("idle_state", state, 0);
    chk("idle_fill", fill, 0);

    // Basic capture.
    do_arm();
    chk("arm_state", state, 1);
    for (int i = 1; i <= 5; i++) put(TW'(i));
    chk("b_fill_pre", fill, 5);
    rd_if.rd_ready_i = 1'b1;
    trig_now(0);
    chk("b_state_done", state, 3);
    chk("b_fill", fill, 5);
    chk("b_wrapped", wrapped, 0);
    chk("b_lat0", rd_if.rd_valid_o, 0);
    tick();
    chk("b_lat1", rd_if.rd_valid_o, 0);
    tick();
    chk("b_lat2", rd_if.rd_valid_o, 1);
    drain(5, 5, 36'h1, 1'b0, 1'b1);
    chk("b_state_idle", state, 0);
    chk("b_valid_off", rd_if.rd_valid_o, 0);
    chk("b_fill_kept", fill, 5);

    // Wrap and post-trigger window.
    do_arm();
    post_trig = 4;
    for (int i = 1; i <= 20; i++) begin
      trap = (i == 16);
      put(TW'(i));
      trap = 1'b0;
      if (i == 16) chk("w_state_post", state, 2);
      if (i == 19) chk("w_state_post2", state, 2);
    end
    chk("w_state_done", state, 3);
    chk("w_fill", fill, 16);
    chk("w_wrapped", wrapped, 1);
    drain(16, 16, 36'h5, 1'b0, 1'b1);
    chk("w_state_idle", state, 0);

    // Backpressure.
    do_arm();
    for (int i = 0; i < 12; i++) put(36'h100 + TW'(i));
    trig_now(0);
    chk("bp_fill", fill, 12);
    drain(12, 12, 36'h100, 1'b1, 1'b0);
    chk("bp_state_idle", state, 0);

    // Empty window.
    do_arm();
    trig_now(0);
    chk("e_state_done", state, 3);
    chk("e_valid0", rd_if.rd_valid_o, 0);
    tick();
    chk("e_state_idle", state, 0);
    chk("e_valid1", rd_if.rd_valid_o, 0);
    tick();
    chk("e_valid2", rd_if.rd_valid_o, 0);
    chk("e_fill", fill, 0);

    // Abort mid-readout.
    do_arm();
    for (int i = 0; i < 16; i++) put(36'h200 + TW'(i));
    trig_now(0);
    chk("a_fill", fill, 16);
    chk("a_wrapped", wrapped, 0);
    drain(3, 16, 36'h200, 1'b0, 1'b1);
    rd_if.rd_ready_i = 1'b0;
    chk("a_pre_valid", rd_if.rd_valid_o, 1);
    do_arm();
    chk("a_valid_drop", rd_if.rd_valid_o, 0);
    chk("a_fill0", fill, 0);
    chk("a_state", state, 1);

    // Async reset in POST.
    post_trig = 5;
    for (int i = 0; i < 17; i++) begin
      trap = (i == 16);
      put(36'h300 + TW'(i));
      trap = 1'b0;
    end
    put(36'h3ff);
    chk("r_state_post", state, 2);
    chk("r_wrapped_pre", wrapped, 1);
    #2 rst = 1'b1;
    #1;
    chk("r_state", state, 0);
    chk("r_fill", fill, 0);
    chk("r_wrapped", wrapped, 0);
    chk("r_valid", rd_if.rd_valid_o, 0);
    chk("r_last", rd_if.rd_last_o, 0);
    chk("r_data", rd_if.rd_data_o, 0);
    tick();
    rst = 1'b0;
    tick();

`ifdef RV_TRACE_RECORDER_TIMESTAMP_EN
    do_arm();
    repeat (2) tick();
    put(36'h1);
    repeat (6) tick();
    put(36'h2);
    repeat (69999) tick();
    put(36'h3);
    trig_now(0);
    drain(3, 3, 36'h1, 1'b0, 1'b1);
    chk("ts_0", rx[0][EW-1:TW], 3);
    chk("ts_1", rx[1][EW-1:TW], 7);
    chk("ts_2", rx[2][EW-1:TW], 16'hffff);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rv_trace_recorder.md
# rv_trace_recorder

On-chip replacement for the picorv32 demo's simulation-only trace dump. It captures the core's `trace_valid`/`trace_data` stream into a circular buffer while armed, freezes the buffer a programmable number of entries after a trigger (CPU trap or software strobe), and then streams the captured window out oldest-first over a valid/ready port. It sits beside `picorv32_demo_system` and connects to its `trace_valid_o`, `trace_data_o` and `trap_o`.

## Interface
- `TRACE_WIDTH`, default 36: width of one trace word.
- `DEPTH_LOG2`, default 10: buffer holds 2^DEPTH_LOG2 entries.
- `clk_i` input, 1 bit: the single clock.
- `rst_i` input, 1 bit: reset, asynchronous and active-high.
- `trace_valid_i` input, 1 bit: trace word qualifier.
- `trace_data_i` input, TRACE_WIDTH bits: trace word.
- `trap_i` input, 1 bit: level trigger source.
- `sw_trig_i` input, 1 bit: software trigger pulse.
- `arm_i` input, 1 bit: pulse that clears the buffer and starts recording.
- `post_trig_i` input, DEPTH_LOG2 bits: number of entries to capture after the trigger.
- `rd_ready_i` input, 1 bit: readout consumer ready.
- `rd_valid_o` output, 1 bit: readout word valid.
- `rd_data_o` output, EW bits: readout word. EW = TRACE_WIDTH, or TRACE_WIDTH+16 with the timestamp feature (see Configuration).
- `rd_last_o` output, 1 bit: marks the final (newest) entry.
- `state_o` output, 2 bits: IDLE=0, ARMED=1, POST=2, DONE=3.
- `fill_o` output, DEPTH_LOG2+1 bits: number of valid entries.
- `wrapped_o` output, 1 bit: at least one entry was overwritten since arm.

## Operation
- **Reset:** all outputs are 0; state is IDLE; write pointer and fill are 0.
- **`arm_i`** has top priority in every state.
  - Next state is ARMED; wr_ptr, fill and wrapped are cleared.
  - Any readout in progress is aborted: `rd_valid_o` drops the next cycle.
  - A `trace_valid_i` in the same cycle as `arm_i` is not captured.
- **ARMED:** each `trace_valid_i` writes `mem[wr_ptr]`, increments wr_ptr (mod depth), and increments fill, saturating at 2^DEPTH_LOG2. A write while fill is full sets `wrapped_o`.
- **Trigger:** `trap_i` or `sw_trig_i` high while ARMED.
  - A write in the trigger cycle counts as pre-trigger.
  - `post_trig_i` is sampled into the remaining-count register `rem`.
  - If `rem`=0, go to DONE; otherwise go to POST.
- **POST:** writes continue as in ARMED and each write decrements `rem`. The write that brings `rem` to 0 moves the state to DONE. Triggers are ignored in POST.
- **DONE:** no further writes.
  - The read pointer starts at (wr_ptr - fill) mod depth.
  - Entries stream oldest-first. A word transfers when `rd_valid_o` && `rd_ready_i`.
  - `rd_last_o` is high together with the fill-th word.
  - After the last transfer, go to IDLE; fill remains readable on `fill_o` until the next arm.
  - If fill=0 on entering DONE, go to IDLE on the next cycle; `rd_valid_o` never asserts.
- **IDLE:** trace and trigger inputs are ignored.

## Timing
- Write latency: an entry is written in the same cycle `trace_valid_i` is sampled. `fill_o` and `state_o` update on the following edge.
- Readout path uses a synchronous RAM (1-cycle read) plus a 2-entry skid buffer.
  - First `rd_valid_o` asserts exactly 2 cycles after `state_o` becomes DONE.
  - Throughput is sustained 1 word/cycle while `rd_ready_i` is high.
  - `rd_data_o` and `rd_last_o` hold stable while `rd_valid_o` && !`rd_ready_i`.
- `rd_valid_o` never depends combinationally on `rd_ready_i`.

## Configuration
- `RV_TRACE_RECORDER_TIMESTAMP_EN` **defined:**
  - A 16-bit counter counts cycles since the previous captured entry; for the first entry after arm, it counts cycles since the arm.
  - The counter saturates at 0xFFFF and clears on each write.
  - Its value is stored in `rd_data_o[EW-1:TRACE_WIDTH]`, giving EW = TRACE_WIDTH+16.
- **Undefined:** no counter; EW = TRACE_WIDTH.

## Structure
- Package `rv_trace_pkg` holds:
  - the state encoding constants (IDLE/ARMED/POST/DONE);
  - `TS_WIDTH`=16;
  - the EW derivation macro.
- Sub-module `rv_trace_ram`: simple dual-port memory, 2^DEPTH_LOG2 × EW, one write port, registered read port. It must be inferable as block RAM.
- Top level contains the FSM, the pointers, the `rem` counter and the skid buffer.

## Test plan
Parameters for all scenarios: DEPTH_LOG2=4, TRACE_WIDTH=36.
- **Basic capture:** arm, 5 valid words 0x1..0x5, `sw_trig_i` with `post_trig_i`=0 → DONE, `fill_o`=5, `wrapped_o`=0; readout with ready held high gives 0x1..0x5 on consecutive cycles, `rd_last_o` on 0x5, then IDLE.
- **Wrap and post-trigger:** arm, 20 words 0x1..0x14 with `trap_i` asserted alongside word 0x10 and `post_trig_i`=4 → DONE after word 0x14, `fill_o`=16, `wrapped_o`=1; readout gives 0x5..0x14.
- **Backpressure:** during readout, toggle `rd_ready_i` pseudo-randomly → no word dropped or duplicated; data stays stable while stalled.
- **Empty window:** arm, then `sw_trig_i` immediately with no valid words → DONE for one cycle, then IDLE; `rd_valid_o` stays 0.
- **Abort mid-readout:** `arm_i` after 3 of 16 words have been read → `rd_valid_o` drops the next cycle, `fill_o`=0, state ARMED; async `rst_i` mid-POST → all outputs 0 immediately.
- **Timestamp** (`RV_TRACE_RECORDER_TIMESTAMP_EN` defined): words spaced 3, 7 and 70000 cycles apart → stored deltas 3, 7, 0xFFFF.
